// File: rtl/i2c_target.sv
// I2C target: filters SCL/SDA on cpu_clk, decodes START/STOP and bytes,
// and presents a byte-wide register port with an auto-incrementing subaddress.
module i2c_target #(
   parameter logic [6:0] DEV_ADDR = 7'h39,
   parameter int         FILT_LEN = 3
) (
   input  logic       cpu_clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   // state     | meaning
   // IDLE      | bus free or not yet addressed
   // ADDR      | shifting in the address byte
   // ADDR_ACK  | acknowledging our address
   // SUB       | shifting in the subaddress byte
   // SUB_ACK   | acknowledging the subaddress
   // WDATA     | shifting in a write data byte
   // WDATA_ACK | acknowledging a write data byte
   // RDATA     | driving a read data byte
   // RACK      | sampling the master's ACK/NACK
   // IGNORE    | not for us (or read ended); wait for START/STOP
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_ADDR      = 4'd1;
   localparam logic [3:0] S_ADDR_ACK  = 4'd2;
   localparam logic [3:0] S_SUB       = 4'd3;
   localparam logic [3:0] S_SUB_ACK   = 4'd4;
   localparam logic [3:0] S_WDATA     = 4'd5;
   localparam logic [3:0] S_WDATA_ACK = 4'd6;
   localparam logic [3:0] S_RDATA     = 4'd7;
   localparam logic [3:0] S_RACK      = 4'd8;
   localparam logic [3:0] S_IGNORE    = 4'd9;

   localparam int             CW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_LEN - 1);

   logic          scl_s1, scl_s2, sda_s1, sda_s2;
   logic          scl_f, sda_f, scl_prev, sda_prev;
   logic [CW-1:0] scl_cnt, sda_cnt;
   logic          scl_rise, scl_fall, start_det, stop_det;
   logic [3:0]    state;
   logic [2:0]    bit_cnt;
   logic [6:0]    sh;
   logic [7:0]    byte_in;
   logic          rw, ack_drv, rd_load, inc_pend;

   // two-flop synchronizers; lines idle high
   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
      end else begin
         scl_s1 <= scl_in;
         scl_s2 <= scl_s1;
         sda_s1 <= sda_in;
         sda_s2 <= sda_s1;
      end
   end

   // SCL filter: follow the synchronized line only after FILT_LEN differing samples
   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         scl_f   <= 1'b1;
         scl_cnt <= '0;
      end else if (scl_s2 == scl_f) begin
         scl_cnt <= '0;
      end else if (scl_cnt == CNT_MAX) begin
         scl_f   <= scl_s2;
         scl_cnt <= '0;
      end else begin
         scl_cnt <= scl_cnt + CW'(1);
      end
   end

   // SDA filter, same rule as SCL
   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         sda_f   <= 1'b1;
         sda_cnt <= '0;
      end else if (sda_s2 == sda_f) begin
         sda_cnt <= '0;
      end else if (sda_cnt == CNT_MAX) begin
         sda_f   <= sda_s2;
         sda_cnt <= '0;
      end else begin
         sda_cnt <= sda_cnt + CW'(1);
      end
   end

   // previous filtered values for edge detection
   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_prev <= scl_f;
         sda_prev <= sda_f;
      end
   end

   assign scl_rise  = scl_f & ~scl_prev;
   assign scl_fall  = ~scl_f & scl_prev;
   assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
   assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;
   assign byte_in   = {sh, sda_f};
   assign busy      = (state != S_IDLE) && (state != S_IGNORE) && (state != S_ADDR);

   // protocol FSM; START/STOP override any bit event in the same cycle
   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         sda_oe    <= 1'b0;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         bit_cnt   <= 3'd0;
         sh        <= 7'd0;
         rw        <= 1'b0;
         ack_drv   <= 1'b0;
         rd_load   <= 1'b0;
         inc_pend  <= 1'b0;
      end else begin
         reg_we   <= 1'b0;
         inc_pend <= 1'b0;
         // post-write increment lands one cycle after the strobe
         if (inc_pend)
            reg_addr <= reg_addr + 8'h01;
         if (start_det) begin
            state   <= S_ADDR;
            bit_cnt <= 3'd0;
            sda_oe  <= 1'b0;
            ack_drv <= 1'b0;
            rd_load <= 1'b0;
         end else if (stop_det) begin
            state   <= S_IDLE;
            sda_oe  <= 1'b0;
            ack_drv <= 1'b0;
            rd_load <= 1'b0;
         end else begin
            case (state)
               S_ADDR, S_SUB, S_WDATA: begin
                  if (scl_rise) begin
                     sh      <= byte_in[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (state == S_ADDR) begin
                           if (byte_in[7:1] == DEV_ADDR) begin
                              rw    <= byte_in[0];
                              state <= S_ADDR_ACK;
                           end else begin
                              state <= S_IGNORE;
                           end
                        end else if (state == S_SUB) begin
                           reg_addr <= byte_in;
                           state    <= S_SUB_ACK;
                        end else begin
                           reg_wdata <= byte_in;
                           reg_we    <= 1'b1;
                           inc_pend  <= 1'b1;
                           state     <= S_WDATA_ACK;
                        end
                     end
                  end
               end
               S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                  if (scl_fall) begin
                     if (!ack_drv) begin
                        sda_oe  <= 1'b1;
                        ack_drv <= 1'b1;
                     end else begin
                        ack_drv <= 1'b0;
                        sda_oe  <= 1'b0;
                        if (state == S_ADDR_ACK && rw) begin
                           sh     <= reg_rdata[6:0];
                           sda_oe <= ~reg_rdata[7];
                           state  <= S_RDATA;
                        end else if (state == S_ADDR_ACK) begin
                           state <= S_SUB;
                        end else begin
                           state <= S_WDATA;
                        end
                     end
                  end
               end
               S_RDATA: begin
                  if (scl_fall) begin
                     if (rd_load) begin
                        sh      <= reg_rdata[6:0];
                        sda_oe  <= ~reg_rdata[7];
                        rd_load <= 1'b0;
                     end else begin
                        sda_oe <= ~sh[6];
                        sh     <= {sh[5:0], 1'b0};
                     end
                  end
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        state <= S_RACK;
                  end
               end
               S_RACK: begin
                  if (scl_fall)
                     sda_oe <= 1'b0;
                  if (scl_rise) begin
                     if (!sda_f) begin
                        reg_addr <= reg_addr + 8'h01;
                        rd_load  <= 1'b1;
                        state    <= S_RDATA;
                     end else begin
                        state <= S_IGNORE;
                     end
                  end
               end
               S_IDLE, S_IGNORE: ;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
